// File: rtl/iterative_shifter_pkg.sv
// Shared types and flag bit positions for the iterative shift/rotate unit.
package iterative_shifter_pkg;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_RCL = 3'd2,
    OP_RCR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_SAR = 3'd6
  } ShiftOp_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int CF_IDX = 0;
  localparam int PF_IDX = 2;
  localparam int AF_IDX = 4;
  localparam int ZF_IDX = 6;
  localparam int SF_IDX = 7;
  localparam int OF_IDX = 11;

  // Only the true shifts rewrite PF/SF/ZF; rotates leave them alone.
  function automatic logic is_shift_op(input ShiftOp_t op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// One-position shift/rotate step with the carry and overflow it produces.
module shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       i_op,
  input  logic             i_is_8_bit,
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_cf,
  output logic [WIDTH-1:0] o_val,
  output logic             o_cf,
  output logic             o_of
);

  localparam int IW = $clog2(WIDTH);

  ShiftOp_t         w_op;
  logic [IW-1:0]    w_msb_idx;
  logic [IW-1:0]    w_msb1_idx;
  logic             w_msb;
  logic             w_lsb;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;
  logic [WIDTH-1:0] w_res;
  logic             w_cf;

  // Build the stepped value and the bit that falls off the active end.
  always_comb begin
    w_op       = ShiftOp_t'(i_op);
    w_msb_idx  = i_is_8_bit ? IW'(7) : IW'(WIDTH - 1);
    w_msb1_idx = i_is_8_bit ? IW'(6) : IW'(WIDTH - 2);
    w_msb      = i_val[w_msb_idx];
    w_lsb      = i_val[0];
    w_left     = {i_val[WIDTH-2:0], 1'b0};
    w_right    = {1'b0, i_val[WIDTH-1:1]};
    w_res      = i_val;
    w_cf       = i_cf;
    case (w_op)
      OP_ROL: begin w_res = w_left;  w_res[0] = w_msb;         w_cf = w_msb; end
      OP_ROR: begin w_res = w_right; w_res[w_msb_idx] = w_lsb; w_cf = w_lsb; end
      OP_RCL: begin w_res = w_left;  w_res[0] = i_cf;          w_cf = w_msb; end
      OP_RCR: begin w_res = w_right; w_res[w_msb_idx] = i_cf;  w_cf = w_lsb; end
      OP_SHL: begin w_res = w_left;                            w_cf = w_msb; end
      OP_SHR: begin w_res = w_right;                           w_cf = w_lsb; end
      OP_SAR: begin w_res = w_right; w_res[w_msb_idx] = w_msb; w_cf = w_lsb; end
      default: ;
    endcase
    // Left shifts in byte mode push bit 7 into bit 8; keep the upper part clear.
    w_res = w_res & (i_is_8_bit ? WIDTH'(8'hFF) : {WIDTH{1'b1}});
  end

  // Overflow definition differs per operation family.
  always_comb begin
    o_val = w_res;
    o_cf  = w_cf;
    case (w_op)
      OP_ROL, OP_RCL, OP_SHL: o_of = w_res[w_msb_idx] ^ w_cf;
      OP_ROR, OP_RCR:         o_of = w_res[w_msb_idx] ^ w_res[w_msb1_idx];
      OP_SHR:                 o_of = w_msb;
      default:                o_of = 1'b0;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start/busy/done handshake.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int COUNT_BITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic             is_8_bit,
  input  logic [WIDTH-1:0] a,
  input  logic [7:0]       count,
  input  logic [15:0]      flags_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [15:0]      flags_out
);

  state_t                r_state;
  logic [COUNT_BITS-1:0] r_rem;
  logic [WIDTH-1:0]      r_val;
  logic                  r_cf;
  logic [2:0]            r_op;
  logic                  r_b8;
  logic [15:0]           r_flags;
  logic [WIDTH-1:0]      r_out;
  logic [15:0]           r_flags_out;
  logic                  r_busy;
  logic                  r_done;

  logic [COUNT_BITS-1:0] w_count;
  logic [WIDTH-1:0]      w_a_active;
  logic [WIDTH-1:0]      w_step_val;
  logic                  w_step_cf;
  logic                  w_step_of;
  logic                  w_res_msb;
  logic [15:0]           w_final_flags;
  logic                  w_unused_count;

  assign w_count        = count[COUNT_BITS-1:0];
  assign w_unused_count = ^count;
  assign w_a_active     = a & (is_8_bit ? WIDTH'(8'hFF) : {WIDTH{1'b1}});

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_op       (r_op),
    .i_is_8_bit (r_b8),
    .i_val      (r_val),
    .i_cf       (r_cf),
    .o_val      (w_step_val),
    .o_cf       (w_step_cf),
    .o_of       (w_step_of)
  );

  // Flags as they would look if the current step were the last one.
  always_comb begin
    w_res_msb             = r_b8 ? w_step_val[7] : w_step_val[WIDTH-1];
    w_final_flags         = r_flags;
    w_final_flags[CF_IDX] = w_step_cf;
    w_final_flags[OF_IDX] = w_step_of;
    if (is_shift_op(ShiftOp_t'(r_op))) begin
      w_final_flags[PF_IDX] = ~^w_step_val[7:0];
      w_final_flags[SF_IDX] = w_res_msb;
      w_final_flags[ZF_IDX] = (w_step_val == '0);
    end
  end

  // Control FSM, step counter and operand/carry registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_val       <= '0;
      r_cf        <= 1'b0;
      r_op        <= '0;
      r_b8        <= 1'b0;
      r_flags     <= '0;
      r_out       <= '0;
      r_flags_out <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A flush in the same cycle drops the start.
          if (start && !flush) begin
            r_val   <= w_a_active;
            r_cf    <= flags_in[CF_IDX];
            r_op    <= op;
            r_b8    <= is_8_bit;
            r_flags <= flags_in;
            r_rem   <= w_count;
            if (w_count == '0) begin
              r_out       <= a;
              r_flags_out <= flags_in;
              r_done      <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_val <= w_step_val;
            r_cf  <= w_step_cf;
            r_rem <= r_rem - 1'b1;
            if (r_rem == COUNT_BITS'(1)) begin
              r_out       <= w_step_val;
              r_flags_out <= w_final_flags;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out       = r_out;
  assign flags_out = r_flags_out;

endmodule

// File: tb/tb_iterative_shifter.sv
// Randomised self-checking bench for iterative_shifter against an arithmetic reference model.
module tb_iterative_shifter;
  import iterative_shifter_pkg::*;

  localparam int W  = 16;
  localparam int CB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          flush;
  logic [2:0]    op;
  logic          is_8_bit;
  logic [W-1:0]  a;
  logic [7:0]    count;
  logic [15:0]   flags_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  out;
  logic [15:0]   flags_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iterative_shifter #(.WIDTH(W), .COUNT_BITS(CB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .is_8_bit  (is_8_bit),
    .a         (a),
    .count     (count),
    .flags_in  (flags_in),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .flags_out (flags_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-count closed-form model: rotates as modular rotations, shifts as big shifts.
  task automatic ref_model(input int opi, input bit b8, input logic [W-1:0] av, input int n,
                           input logic [15:0] fin, output logic [W-1:0] r, output logic [15:0] fo);
    longint unsigned x, mask, wmask, y, ry, res;
    longint s;
    int w, k;
    bit cf, of;
    w     = b8 ? 8 : W;
    mask  = (64'd1 << w) - 1;
    wmask = (64'd1 << (w + 1)) - 1;
    x     = longint'(av) & mask;
    fo    = fin;
    r     = av;
    if (n == 0) return;
    res = 0; cf = 0; of = 0;
    case (opi)
      0: begin
        k = n % w;
        res = ((x << k) | (x >> (w - k))) & mask;
        cf = res[0]; of = res[w-1] ^ cf;
      end
      1: begin
        k = n % w;
        res = ((x >> k) | (x << (w - k))) & mask;
        cf = res[w-1]; of = res[w-1] ^ res[w-2];
      end
      2: begin
        y = x | (longint'(fin[CF_IDX]) << w);
        k = n % (w + 1);
        ry = ((y << k) | (y >> (w + 1 - k))) & wmask;
        res = ry & mask; cf = ry[w]; of = res[w-1] ^ cf;
      end
      3: begin
        y = x | (longint'(fin[CF_IDX]) << w);
        k = n % (w + 1);
        ry = ((y >> k) | (y << (w + 1 - k))) & wmask;
        res = ry & mask; cf = ry[w]; of = res[w-1] ^ res[w-2];
      end
      4: begin
        res = (x << n) & mask;
        ry = (x << n) >> w;
        cf = ry[0]; of = res[w-1] ^ cf;
      end
      5: begin
        res = x >> n;
        ry = x >> (n - 1);
        cf = ry[0]; of = ry[w-1];
      end
      default: begin
        s = x[w-1] ? (longint'(x) - (longint'(1) << w)) : longint'(x);
        res = longint'(s >>> n) & mask;
        ry = longint'(s >>> (n - 1));
        cf = ry[0]; of = 1'b0;
      end
    endcase
    fo[CF_IDX] = cf;
    fo[OF_IDX] = of;
    if (opi >= 4) begin
      fo[PF_IDX] = ~^res[7:0];
      fo[SF_IDX] = res[w-1];
      fo[ZF_IDX] = (res == 0);
    end
    r = res[W-1:0];
  endtask

  // Called at a negedge with the unit idle (or in its done cycle); returns in the done cycle.
  task automatic run_op(input int opi, input bit b8, input logic [W-1:0] av, input logic [7:0] cnt,
                        input logic [15:0] fin, output logic [W-1:0] eo, output logic [15:0] ef);
    int n, cyc, bcyc;
    bit got;
    n = int'(cnt) % (1 << CB);
    ref_model(opi, b8, av, n, fin, eo, ef);
    op = 3'(opi); is_8_bit = b8; a = av; count = cnt; flags_in = fin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; bcyc = 0; got = 0;
    while (cyc <= 80) begin
      if (done) begin got = 1; break; end
      if (busy) bcyc++;
      // Traffic while busy must be ignored.
      start = 1'($urandom); a = W'($urandom); op = 3'($urandom % 7);
      count = 8'($urandom); flags_in = 16'($urandom); is_8_bit = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq("done_seen", 64'(got), 64'd1);
    if (got) begin
      check_eq("latency", 64'(cyc), 64'(n + 1));
      check_eq("busy_cycles", 64'(bcyc), 64'(n));
      check_eq("busy_at_done", 64'(busy), 64'd0);
      check_eq("out", 64'(out), 64'(eo));
      check_eq("flags_out", 64'(flags_out), 64'(ef));
    end
    $display("[TB] op=%0d b8=%0d a=0x%h n=%0d -> out=0x%h flags=0x%h lat=%0d",
             opi, b8, av, n, out, flags_out, cyc);
  endtask

  initial begin
    logic [W-1:0] eo, prior_out;
    logic [15:0]  ef, prior_flags;
    int done_cnt;

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; is_8_bit = 1'b0;
    a = '0; count = '0; flags_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_out", 64'(out), 64'd0);
    check_eq("rst_flags", 64'(flags_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations.
    run_op(0, 1'b0, 16'h8001, 8'd1, 16'h00C4, eo, ef);
    check_eq("rol_out_k", 64'(out), 64'h0003);
    check_eq("rol_flags_k", 64'(flags_out), 64'h08C5);
    run_op(3, 1'b1, 16'h0001, 8'd2, 16'h0000, eo, ef);
    check_eq("rcr_out_k", 64'(out), 64'h0080);
    check_eq("rcr_flags_k", 64'(flags_out), 64'h0800);
    run_op(4, 1'b0, 16'h4000, 8'h21, 16'h0000, eo, ef);
    check_eq("shl_out_k", 64'(out), 64'h8000);
    check_eq("shl_flags_k", 64'(flags_out), 64'h0884);
    run_op(2, 1'b0, 16'h1234, 8'h20, 16'hABCD, eo, ef);
    check_eq("cnt0_out_k", 64'(out), 64'h1234);
    check_eq("cnt0_flags_k", 64'(flags_out), 64'hABCD);
    run_op(6, 1'b0, 16'h8000, 8'd15, 16'h0001, eo, ef);
    check_eq("sar_out_k", 64'(out), 64'hFFFF);
    check_eq("sar_flags_k", 64'(flags_out), 64'h0084);
    @(negedge clk);

    // Reset in the middle of a long shift.
    op = 3'd5; is_8_bit = 1'b0; a = 16'hBEEF; count = 8'd10; flags_in = 16'h0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_eq("abort_rst_busy", 64'(busy), 64'd0);
    check_eq("abort_rst_out", 64'(out), 64'd0);
    check_eq("abort_rst_flags", 64'(flags_out), 64'd0);
    done_cnt = 0;
    repeat (14) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check_eq("abort_rst_nodone", 64'(done_cnt), 64'd0);

    // Flush in the middle of a long shift, then restart at T+6.
    run_op(1, 1'b0, 16'h00F1, 8'd3, 16'h0010, prior_out, prior_flags);
    @(negedge clk);
    op = 3'd5; is_8_bit = 1'b0; a = 16'h7777; count = 8'd10; flags_in = 16'h0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_done_t5", 64'(done), 64'd0);
    check_eq("flush_out_hold", 64'(out), 64'(prior_out));
    check_eq("flush_flags_hold", 64'(flags_out), 64'(prior_flags));
    @(negedge clk);
    check_eq("flush_done_t6", 64'(done), 64'd0);
    run_op(5, 1'b0, 16'hC3A5, 8'd4, 16'h0801, prior_out, prior_flags);
    @(negedge clk);

    // Flush together with start in idle drops the start.
    op = 3'd0; a = 16'h5555; count = 8'd0; flags_in = 16'h1111; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check_eq("flush_start_done", 64'(done), 64'd0);
    check_eq("flush_start_out", 64'(out), 64'(prior_out));
    @(negedge clk);

    // Randomised transactions, issued back-to-back in each done cycle.
    repeat (150) begin
      run_op(int'($urandom % 7), 1'($urandom), W'($urandom), 8'($urandom), 16'($urandom), eo, ef);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
